bus_arbiter2: RTL and testbench

//  Two-master round-robin arbiter for the shared 32-bit stb/ack system bus (RAM, LED/button

---
 rtl/bus_arbiter2_if.sv | 16 +
 rtl/bus_arbiter2.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter2.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter2_if.sv
// One stb/ack bus attachment: the master modport drives a request, the slave modport answers it.
interface bus_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   wdat;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            stb;
    logic            ack;
    logic [DW-1:0]   rdat;

    modport master (output adr, wdat, sel, we, stb, input ack, rdat);
    modport slave  (input adr, wdat, sel, we, stb, output ack, rdat);
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter for the shared stb/ack system bus.
// Define ARB_TIMEOUT_EN to add the hung-slave timeout (forced ack with TO_DATA, sticky timeout_o).
module bus_arbiter2 #(
    parameter int AW = 32,
    parameter int DW = 32,
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 255,
`endif
    parameter logic [DW-1:0] TO_DATA = 32'hDEADBEEF
) (
    input  logic           clk,
    input  logic           rst_i,
    bus_arbiter2_if.slave  m0,
    bus_arbiter2_if.slave  m1,
    bus_arbiter2_if.master s,
    output logic [1:0]     grant_o,
    output logic           timeout_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            last_q, last_d;     // 1: m1 owned the bus most recently
    logic            busy_s, gstb_s, to_hit_s, ack_s;
    logic [AW-1:0]   adr_s;
    logic [DW-1:0]   wdat_s, rdat_s;
    logic [DW/8-1:0] sel_s;
    logic            we_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // Forward the owner's request to the slave; an idle bus drives all zeros.
    always_comb begin
        busy_s = (state_q == BUSY);
        adr_s  = {AW{1'b0}};
        wdat_s = {DW{1'b0}};
        sel_s  = {(DW/8){1'b0}};
        we_s   = 1'b0;
        gstb_s = 1'b0;
        if (busy_s) begin
            case (grant_q)
                2'b01: begin
                    adr_s = m0.adr; wdat_s = m0.wdat; sel_s = m0.sel; we_s = m0.we; gstb_s = m0.stb;
                end
                2'b10: begin
                    adr_s = m1.adr; wdat_s = m1.wdat; sel_s = m1.sel; we_s = m1.we; gstb_s = m1.stb;
                end
                default: begin
                    gstb_s = 1'b0;
                end
            endcase
        end else begin
            gstb_s = 1'b0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Forced termination lands on BUSY cycle TIMEOUT_CYCLES (counter starts at 0 on entry).
    assign to_hit_s  = busy_s && gstb_s && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout_q;
`else
    assign to_hit_s  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign s.adr   = adr_s;
    assign s.wdat  = wdat_s;
    assign s.sel   = sel_s;
    assign s.we    = we_s;
    assign s.stb   = gstb_s & ~to_hit_s;
    assign ack_s   = busy_s & (s.ack | to_hit_s);
    assign rdat_s  = to_hit_s ? TO_DATA : s.rdat;
    assign m0.ack  = ack_s & grant_q[0];
    assign m1.ack  = ack_s & grant_q[1];
    assign m0.rdat = m0.ack ? rdat_s : {DW{1'b0}};
    assign m1.rdat = m1.ack ? rdat_s : {DW{1'b0}};
    assign grant_o = grant_q;

    // Arbitration and transfer sequencing.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0.stb || m1.stb) begin
                    state_d = BUSY;
                    if (m0.stb && m1.stb) begin
                        grant_d = last_q ? 2'b01 : 2'b10;
                    end else if (m0.stb) begin
                        grant_d = 2'b01;
                    end else begin
                        grant_d = 2'b10;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt_d = {CW{1'b0}};
`endif
                end else begin
                    grant_d = 2'b00;
                end
            end
            BUSY: begin
                // Abort, forced timeout and normal completion all hand the bus back the same way.
                if (!gstb_s || to_hit_s || (s.ack && s.stb)) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
`ifdef ARB_TIMEOUT_EN
                    timeout_d = timeout_q | to_hit_s;
`endif
                end else begin
                    state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CW'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers; m0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= {CW{1'b0}};
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end
endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: vector table, directed corner sequences, randomized traffic vs a reference model.
module tb_bus_arbiter2;
    localparam logic [31:0] XK = 32'h12345668;   // slave returns adr ^ XK

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter2_if m0_if();
    bus_arbiter2_if m1_if();
    bus_arbiter2_if s_if();
    logic [1:0] grant;
    logic       timeout;
    int         slave_delay = 0;
    logic       slave_never = 1'b0;
    int         wait_q = 0;

`ifdef ARB_TIMEOUT_EN
    bus_arbiter2 #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_i(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
                                            .grant_o(grant), .timeout_o(timeout));
`else
    bus_arbiter2 dut (.clk(clk), .rst_i(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
                      .grant_o(grant), .timeout_o(timeout));
`endif

    // Slave: acks after slave_delay waiting cycles, combinationally from stb.
    assign s_if.ack  = s_if.stb && !slave_never && (wait_q >= slave_delay);
    assign s_if.rdat = s_if.adr ^ XK;
    always @(posedge clk) wait_q <= (s_if.stb && !s_if.ack) ? wait_q + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk);     endtask

    task automatic drive(input int i, input logic stb, input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat);
        if (i == 0) begin
            m0_if.stb = stb; m0_if.adr = adr; m0_if.we = we; m0_if.sel = sel; m0_if.wdat = dat;
        end else begin
            m1_if.stb = stb; m1_if.adr = adr; m1_if.we = we; m1_if.sel = sel; m1_if.wdat = dat;
        end
    endtask

    task automatic drop(input int i);
        if (i == 0) m0_if.stb = 1'b0; else m1_if.stb = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; drop(0); drop(1); slave_never = 1'b0; slave_delay = 0;
        tick(); rst = 1'b0;
    endtask

    typedef struct {
        logic s0, s1; logic [31:0] a0, a1; logic w0, w1; logic [3:0] l0, l1; logic [31:0] d0, d1;
        logic [1:0] eg; logic [31:0] ea; logic ew; logic [3:0] el; logic [31:0] ed, er;
    } vec_t;
    vec_t vt[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int mo, ml, mw, ostb, esack, acks0, acks1, maxw;
        int wc[2];
        logic ack_seen[2];

        vt[0] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 4'hF, 4'h0, 32'h0, 32'h0,
                  2'b01, 32'h10, 1'b0, 4'hF, 32'h0, 32'h12345678};
        vt[1] = '{1'b0, 1'b1, 32'h0, 32'h01000000, 1'b0, 1'b1, 4'h0, 4'h1, 32'h0, 32'hA5,
                  2'b10, 32'h01000000, 1'b1, 4'h1, 32'hA5, 32'h13345668};
        vt[2] = '{1'b1, 1'b1, 32'h20, 32'h30, 1'b0, 1'b1, 4'hF, 4'h3, 32'h11111111, 32'hCAFE,
                  2'b01, 32'h20, 1'b0, 4'hF, 32'h11111111, 32'h12345648};
        vt[3] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 4'hC, 4'h0, 32'hBEEF0000, 32'h0,
                  2'b01, 32'h40, 1'b1, 4'hC, 32'hBEEF0000, 32'h12345628};

        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        mid();
        chk("reset grant", grant, 2'b00);
        chk("reset s_stb", s_if.stb, 1'b0);
        chk("reset s_adr", s_if.adr, 32'h0);
        chk("reset acks", {m1_if.ack, m0_if.ack}, 2'b00);
        chk("reset m0_dat", m0_if.rdat, 32'h0);
        chk("reset timeout", timeout, 1'b0);
        tick();

        // Single transfers from a fresh reset, zero-wait slave.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            drive(0, vt[v].s0, vt[v].a0, vt[v].w0, vt[v].l0, vt[v].d0);
            drive(1, vt[v].s1, vt[v].a1, vt[v].w1, vt[v].l1, vt[v].d1);
            mid();
            chk($sformatf("vec%0d arb grant", v), grant, 2'b00);
            chk($sformatf("vec%0d arb s_stb", v), s_if.stb, 1'b0);
            tick(); mid();
            chk($sformatf("vec%0d grant", v), grant, vt[v].eg);
            chk($sformatf("vec%0d s_adr", v), s_if.adr, vt[v].ea);
            chk($sformatf("vec%0d s_we", v), s_if.we, vt[v].ew);
            chk($sformatf("vec%0d s_sel", v), s_if.sel, vt[v].el);
            chk($sformatf("vec%0d s_dat", v), s_if.wdat, vt[v].ed);
            chk($sformatf("vec%0d s_stb", v), s_if.stb, 1'b1);
            chk($sformatf("vec%0d acks", v), {m1_if.ack, m0_if.ack}, vt[v].eg);
            chk($sformatf("vec%0d m0_dat", v), m0_if.rdat, vt[v].eg[0] ? vt[v].er : 32'h0);
            chk($sformatf("vec%0d m1_dat", v), m1_if.rdat, vt[v].eg[1] ? vt[v].er : 32'h0);
            tick(); drop(0); drop(1); mid();
            chk($sformatf("vec%0d end grant", v), grant, 2'b00);
            tick();
        end

        // m0 served alone, then a tie must go to m1, then the held m0.
        do_reset();
        drive(0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        tick(); mid();
        chk("alt m0 ack", m0_if.ack, 1'b1);
        chk("alt m0 dat", m0_if.rdat, 32'h100 ^ XK);
        tick(); drop(0); mid();
        chk("alt idle grant", grant, 2'b00);
        tick();
        drive(0, 1'b1, 32'h200, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 32'h300, 1'b0, 4'hF, 32'h0);
        tick(); mid();
        chk("alt tie grant", grant, 2'b10);
        chk("alt m1 dat", m1_if.rdat, 32'h300 ^ XK);
        chk("alt m0 no ack", m0_if.ack, 1'b0);
        tick(); drop(1); mid();
        tick(); mid();
        chk("alt held m0 grant", grant, 2'b01);
        chk("alt m0 dat2", m0_if.rdat, 32'h200 ^ XK);
        tick(); drop(0);

        // Slave waits 3 cycles; m1 requests mid-transfer and is served next.
        do_reset();
        slave_delay = 3;
        drive(0, 1'b1, 32'h400, 1'b1, 4'hF, 32'h55);
        tick();
        for (int k = 1; k <= 4; k++) begin
            mid();
            chk($sformatf("wait c%0d s_stb", k), s_if.stb, 1'b1);
            chk($sformatf("wait c%0d m0 ack", k), m0_if.ack, (k == 4));
            chk($sformatf("wait c%0d m1 ack", k), m1_if.ack, 1'b0);
            chk($sformatf("wait c%0d grant", k), grant, 2'b01);
            tick();
            if (k == 1) drive(1, 1'b1, 32'h500, 1'b0, 4'hF, 32'h0);
            if (k == 4) begin drop(0); slave_delay = 0; end
        end
        mid();
        chk("wait idle grant", grant, 2'b00);
        tick(); mid();
        chk("wait m1 grant", grant, 2'b10);
        chk("wait m1 dat", m1_if.rdat, 32'h500 ^ XK);
        tick(); drop(1);

        // Reset asserted in the middle of BUSY.
        do_reset();
        slave_never = 1'b1;
        drive(0, 1'b1, 32'h900, 1'b0, 4'hF, 32'h0);
        tick(); mid();
        chk("rst busy s_stb", s_if.stb, 1'b1);
        tick(); #2 rst = 1'b1; #1;
        chk("rst async s_stb", s_if.stb, 1'b0);
        chk("rst async grant", grant, 2'b00);
        chk("rst async ack", m0_if.ack, 1'b0);
        drop(0); tick(); tick(); rst = 1'b0;

        // Abort by m1 still records m1 as last owner.
        do_reset();
        drive(0, 1'b1, 32'h600, 1'b0, 4'hF, 32'h0);
        tick(); tick(); drop(0);
        slave_never = 1'b1;
        drive(1, 1'b1, 32'h700, 1'b0, 4'hF, 32'h0);
        tick(); mid();
        chk("abort grant", grant, 2'b10);
        tick(); drop(1); mid();
        chk("abort s_stb", s_if.stb, 1'b0);
        chk("abort no ack", m1_if.ack, 1'b0);
        tick(); mid();
        chk("abort idle grant", grant, 2'b00);
        tick();
        slave_never = 1'b0;
        drive(0, 1'b1, 32'h610, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 32'h710, 1'b0, 4'hF, 32'h0);
        tick(); mid();
        chk("abort tie grant", grant, 2'b01);
        tick(); drop(0); drop(1); tick();

        // Randomized traffic against a transaction-level model.
        do_reset();
        mo = 0; ml = 2; mw = 0; acks0 = 0; acks1 = 0; maxw = 0;
        wc[0] = 0; wc[1] = 0; ack_seen[0] = 1'b0; ack_seen[1] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (ack_seen[i]) drop(i);
                else if (!((i == 0) ? m0_if.stb : m1_if.stb) && $urandom_range(0, 2) == 0)
                    drive(i, 1'b1, $urandom, 1'($urandom), 4'($urandom), $urandom);
            end
            slave_delay = $urandom_range(0, 2);
            mid();
            ostb  = (mo == 1) ? int'(m0_if.stb) : (mo == 2) ? int'(m1_if.stb) : 0;
            esack = (ostb != 0 && mw >= slave_delay) ? 1 : 0;
            chk("rnd grant", grant, {mo == 2, mo == 1});
            chk("rnd s_stb", s_if.stb, ostb);
            chk("rnd s_adr", s_if.adr, (mo == 1) ? m0_if.adr : (mo == 2) ? m1_if.adr : 32'h0);
            chk("rnd s_we", s_if.we, (mo == 1) ? m0_if.we : (mo == 2) ? m1_if.we : 1'b0);
            chk("rnd m0 ack", m0_if.ack, (mo == 1 && esack != 0));
            chk("rnd m1 ack", m1_if.ack, (mo == 2 && esack != 0));
            chk("rnd m0 dat", m0_if.rdat, (mo == 1 && esack != 0) ? m0_if.adr ^ XK : 32'h0);
            chk("rnd m1 dat", m1_if.rdat, (mo == 2 && esack != 0) ? m1_if.adr ^ XK : 32'h0);
            ack_seen[0] = (mo == 1 && esack != 0);
            ack_seen[1] = (mo == 2 && esack != 0);
            if (ack_seen[0]) acks0++;
            if (ack_seen[1]) acks1++;
            for (int i = 0; i < 2; i++) begin
                if (((i == 0) ? m0_if.stb : m1_if.stb) && !ack_seen[i]) wc[i]++; else wc[i] = 0;
                if (wc[i] > maxw) maxw = wc[i];
            end
            mw = (ostb != 0 && esack == 0) ? mw + 1 : 0;
            if (mo == 0) begin
                if (m0_if.stb && m1_if.stb) mo = (ml == 2) ? 1 : 2;
                else if (m0_if.stb) mo = 1;
                else if (m1_if.stb) mo = 2;
            end else if (ostb == 0 || esack != 0) begin
                ml = mo; mo = 0; mw = 0;
            end
            tick();
        end
        chk("rnd m0 served", acks0 > 20, 1'b1);
        chk("rnd m1 served", acks1 > 20, 1'b1);
        chk("rnd wait bound", maxw <= 10, 1'b1);
        drop(0); drop(1); tick(); tick();

        // Slave never answers.
        do_reset();
        slave_never = 1'b1;
        drive(0, 1'b1, 32'h800, 1'b0, 4'hF, 32'h0);
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            mid();
            chk($sformatf("to c%0d ack", k), m0_if.ack, (k == 8));
            chk($sformatf("to c%0d s_stb", k), s_if.stb, (k != 8));
            chk($sformatf("to c%0d flag", k), timeout, 1'b0);
            if (k == 8) chk("to data", m0_if.rdat, 32'hDEADBEEF);
            tick();
        end
        drop(0); mid();
        chk("to idle grant", grant, 2'b00);
        chk("to flag set", timeout, 1'b1);
        slave_never = 1'b0;
        tick();
        drive(1, 1'b1, 32'hA00, 1'b0, 4'hF, 32'h0);
        tick(); mid();
        chk("to next m1 ack", m1_if.ack, 1'b1);
        chk("to flag sticky", timeout, 1'b1);
        tick(); drop(1);
        do_reset(); mid();
        chk("to flag cleared", timeout, 1'b0);
        tick();
`else
        for (int k = 1; k <= 20; k++) begin
            mid();
            chk($sformatf("hang c%0d ack", k), m0_if.ack, 1'b0);
            tick();
        end
        mid();
        chk("hang grant", grant, 2'b01);
        chk("hang flag", timeout, 1'b0);
        tick(); drop(0); tick(); mid();
        chk("hang abort grant", grant, 2'b00);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
